warp_scheduler: RTL

- Per-core control FSM that drives `core_state` to every ALU, LSU, PC unit and register file in the core.
- Sequences each instruction through fetch, decode, operand request, memory wait, execute and update.
- Advances the shared program counter and signals kernel completion on RET.
- It is the initiator of the `core_state` interface that the per-thread ALUs respond to: an ALU computes only in cycles where this block presents EXECUTE (3'b101).

---
 rtl/warp_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/warp_scheduler.sv
// Per-core control FSM: steps each instruction through fetch, decode, operand
// request, memory wait, execute and update, and owns the shared program counter.
module warp_scheduler #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_WIDTH          = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [THREADS_PER_BLOCK-1:0]           thread_enable,
    input  logic                                   instruction_ready,
    input  logic                                   decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
    input  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0]  next_pc,
    output logic [2:0]                             core_state,
    output logic [PC_WIDTH-1:0]                    current_pc,
    output logic                                   done
);

    localparam int unsigned LSU_W = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    localparam logic [LSU_W-1:0] LSU_REQUESTING = 2'b01;
    localparam logic [LSU_W-1:0] LSU_WAITING    = 2'b10;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                done_q, done_d;

    logic                mem_stall_c;
    logic [PC_WIDTH-1:0] sel_pc_c;

    // Any enabled lane still talking to memory holds the core in WAIT.
    always_comb begin
        mem_stall_c = 1'b0;
        for (int i = 0; i < int'(THREADS_PER_BLOCK); i++) begin
            if (thread_enable[i] &&
                ((lsu_state[LSU_W*i +: LSU_W] == LSU_REQUESTING) ||
                 (lsu_state[LSU_W*i +: LSU_W] == LSU_WAITING))) begin
                mem_stall_c = 1'b1;
            end
        end
    end

    // Lowest-index enabled lane supplies the PC; with no lanes enabled, step by one.
    always_comb begin
        sel_pc_c = pc_q + PC_WIDTH'(1);
        for (int i = int'(THREADS_PER_BLOCK) - 1; i >= 0; i--) begin
            if (thread_enable[i]) begin
                sel_pc_c = next_pc[PC_WIDTH*i +: PC_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   if (instruction_ready) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if (!mem_stall_c) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                if (decoded_ret) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = sel_pc_c;
                end
            end
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    assign core_state = state_q;
    assign current_pc = pc_q;
    assign done       = done_q;

endmodule
